// File: rtl/conv_pkg.sv
// Shared constants, memory selects and pooling FSM states
// for the CONV accelerator layer stages.
package conv_pkg;

  localparam int DW     = 20;
  localparam int AW     = 12;
  localparam int IMG_W  = 64;
  localparam int POOL_W = IMG_W / 2;
  localparam int IDX_W  = 2 * $clog2(POOL_W);

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } pool_state_t;

endpackage

// File: rtl/conv_maxpool_if.sv
// Layer memory port shared by the CONV stages.
// master: crd/caddr_rd/cwr/caddr_wr/cdata_wr/csel out, cdata_rd in.
interface conv_maxpool_if;

  logic                       crd;
  logic [conv_pkg::AW-1:0]    caddr_rd;
  logic [conv_pkg::DW-1:0]    cdata_rd;
  logic                       cwr;
  logic [conv_pkg::AW-1:0]    caddr_wr;
  logic [conv_pkg::DW-1:0]    cdata_wr;
  logic [2:0]                 csel;

  modport master (
    output crd, caddr_rd, cwr,
    output caddr_wr, cdata_wr, csel,
    input  cdata_rd
  );

  modport slave (
    input  crd, caddr_rd, cwr,
    input  caddr_wr, cdata_wr, csel,
    output cdata_rd
  );

endinterface

// File: rtl/conv_pool_agen.sv
// Window address generator: (idx, k) -> read/write address.
// Read addr = {r, k[1], c, k[0]}; write addr = idx zero-extended.
module conv_pool_agen
  import conv_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       k,
  output logic [AW-1:0]    caddr_rd,
  output logic [AW-1:0]    caddr_wr
);

  localparam int PB = IDX_W / 2;

  assign caddr_rd = {idx[IDX_W-1:PB], k[1],
                     idx[PB-1:0], k[0]};

  assign caddr_wr = {{(AW-IDX_W){1'b0}}, idx};

endmodule

// File: rtl/conv_maxpool.sv
// 2x2 stride-2 max-pool of the 64x64 layer-0 map into layer-1.
// Ports: clk, reset, start, busy, done, mem (layer memory master).
module conv_maxpool
  import conv_pkg::*;
#(
  parameter logic [2:0] SRC_SEL = CSEL_L0,
  parameter logic [2:0] DST_SEL = CSEL_L1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  conv_maxpool_if.master mem
);

  pool_state_t            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [1:0]             k_q, k_d;
  logic signed [DW-1:0]   max_q, max_d;
  logic [AW-1:0]          rd_hold_q, rd_hold_d;
  logic [AW-1:0]          wr_hold_q, wr_hold_d;
  logic [AW-1:0]          rd_addr, wr_addr;
  logic                   sample;

  conv_pool_agen u_agen (
    .idx      (idx_q),
    .k        (k_q),
    .caddr_rd (rd_addr),
    .caddr_wr (wr_addr)
  );

  // Read data lags its address by one cycle, so the sample
  // for address k-1 is taken in RD(k) and the last in CAP.
  assign sample = (state_q == RD && k_q != 2'd0) ||
                  (state_q == CAP);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    k_d       = k_q;
    max_d     = max_q;
    rd_hold_d = rd_hold_q;
    wr_hold_d = wr_hold_q;
    if (sample) begin
      if (state_q == RD && k_q == 2'd1)
        max_d = mem.cdata_rd;
      else if ($signed(mem.cdata_rd) > max_q)
        max_d = mem.cdata_rd;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD;
          k_d     = 2'd0;
        end
      end
      RD: begin
        rd_hold_d = rd_addr;
        k_d       = k_q + 2'd1;
        if (k_q == 2'd3) state_d = CAP;
      end
      CAP: state_d = WR;
      WR: begin
        wr_hold_d = wr_addr;
        if (idx_q == '1) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RD;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      k_q       <= '0;
      max_q     <= '0;
      rd_hold_q <= '0;
      wr_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      k_q       <= k_d;
      max_q     <= max_d;
      rd_hold_q <= rd_hold_d;
      wr_hold_q <= wr_hold_d;
    end
  end

  always_comb begin
    mem.crd      = (state_q == RD);
    mem.cwr      = (state_q == WR);
    mem.caddr_rd = mem.crd ? rd_addr : rd_hold_q;
    mem.caddr_wr = mem.cwr ? wr_addr : wr_hold_q;
    mem.cdata_wr = max_q;
    mem.csel     = 3'b000;
    if (state_q == RD || state_q == CAP)
      mem.csel = SRC_SEL;
    else if (state_q == WR)
      mem.csel = DST_SEL;
    busy = (state_q == RD) || (state_q == CAP) ||
           (state_q == WR);
    done = (state_q == DONE);
  end

endmodule

// File: tb/tb_conv_maxpool.sv
// Self-checking bench for conv_maxpool: memory model,
// protocol monitor, vector tables and a pooling reference.
module tb_conv_maxpool;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  conv_maxpool_if mif ();

  conv_maxpool dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .mem   (mif)
  );

  always #5 clk = ~clk;

  logic [19:0] l0 [4096];
  logic [19:0] l1 [1024];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        rd_p = 1'b0;
  logic [11:0] rd_a_p;
  logic [2:0]  rd_s_p;
  logic        wr_p = 1'b0;
  logic [11:0] wr_a_p;
  logic [19:0] wr_d_p;
  logic [2:0]  wr_s_p;

  int          first_crd, n_crd;
  logic [11:0] crd_a [4];
  int          first_cwr, last_cwr;
  logic [11:0] fw_addr;
  logic [2:0]  fw_sel;
  int          cwr_cnt, done_cnt, done_cyc, viol;
  int          t_start;

  always @(negedge clk) begin
    rd_p   = mif.crd;
    rd_a_p = mif.caddr_rd;
    rd_s_p = mif.csel;
    wr_p   = mif.cwr;
    wr_a_p = mif.caddr_wr;
    wr_d_p = mif.cdata_wr;
    wr_s_p = mif.csel;
    if (mif.crd === 1'b1) begin
      if (first_crd < 0) first_crd = cyc;
      if (n_crd < 4) crd_a[n_crd] = mif.caddr_rd;
      n_crd++;
      if (mif.csel !== 3'b001) viol++;
      if (mif.cwr !== 1'b0) viol++;
    end
    if (mif.cwr === 1'b1) begin
      if (first_cwr < 0) begin
        first_cwr = cyc;
        fw_addr   = mif.caddr_wr;
        fw_sel    = mif.csel;
      end
      last_cwr = cyc;
      cwr_cnt++;
    end else if (mif.csel === 3'b011) begin
      viol++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_p === 1'b1 && rd_s_p == 3'b001)
      mif.cdata_rd <= l0[rd_a_p];
    if (wr_p === 1'b1 && wr_s_p == 3'b011)
      l1[wr_a_p[9:0]] = wr_d_p;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic clear_stats();
    first_crd = -1;
    n_crd     = 0;
    first_cwr = -1;
    last_cwr  = -1;
    cwr_cnt   = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    viol      = 0;
    for (int i = 0; i < 4; i++) crd_a[i] = '1;
    for (int i = 0; i < 1024; i++) l1[i] = 20'hABCDE;
  endtask

  task automatic do_run(input string name);
    int n;
    clear_stats();
    start   = 1'b1;
    t_start = cyc;
    tick();
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 7000) begin
      tick();
      n++;
    end
    chk({name, "_finish"}, done_cnt != 0, 1);
    repeat (5) tick();
  endtask

  // Reference: max of each 2x2 window, signed compare.
  function automatic logic [19:0] ref_pix(int p);
    int r, c, a;
    logic [19:0] m, v;
    r = p / 32;
    c = p % 32;
    a = (2 * r) * 64 + 2 * c;
    m = l0[a];
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = l0[a + dy * 64 + dx];
        if ($signed(v) > $signed(m)) m = v;
      end
    return m;
  endfunction

  task automatic full_compare(input string name);
    int bad, first_bad;
    bad = 0;
    first_bad = -1;
    for (int p = 0; p < 1024; p++)
      if (l1[p] !== ref_pix(p)) begin
        if (first_bad < 0) first_bad = p;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s mismatches=%0d first_idx=%0d",
               name, bad, first_bad);
      $display("  got=%0h required=%0h",
               l1[first_bad], ref_pix(first_bad));
    end
  endtask

  typedef struct {
    bit          load;
    int          pix;
    logic [19:0] s0, s1, s2, s3;
    logic [19:0] exp;
  } vec_t;

  vec_t ramp_tab [4];
  vec_t sgn_tab [3];

  task automatic load_window(input vec_t v);
    int a;
    a = (2 * (v.pix / 32)) * 64 + 2 * (v.pix % 32);
    l0[a]      = v.s0;
    l0[a + 1]  = v.s1;
    l0[a + 64] = v.s2;
    l0[a + 65] = v.s3;
  endtask

  initial begin
    int n, c0;
    ramp_tab[0] = '{0, 0,    0, 0, 0, 0, 20'h00041};
    ramp_tab[1] = '{0, 1,    0, 0, 0, 0, 20'h00043};
    ramp_tab[2] = '{0, 32,   0, 0, 0, 0, 20'h000C1};
    ramp_tab[3] = '{0, 1023, 0, 0, 0, 0, 20'h00FFF};
    sgn_tab[0] = '{1, 0, 20'hFFFFF, 20'h80000,
                   20'h00000, 20'h7FFFF, 20'h7FFFF};
    sgn_tab[1] = '{1, 1, 20'hFFFFF, 20'hFFFFF,
                   20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
    sgn_tab[2] = '{1, 2, 20'h5, 20'h5,
                   20'h5, 20'h5, 20'h00005};

    reset = 1'b1;
    start = 1'b0;
    clear_stats();
    repeat (3) tick();
    chk("reset_outs",
        {busy, done, mif.crd, mif.cwr, mif.caddr_rd,
         mif.caddr_wr, mif.cdata_wr, mif.csel}, 0);
    reset = 1'b0;
    tick();

    // Ramp plus timing
    for (int i = 0; i < 4096; i++) l0[i] = 20'(i);
    do_run("ramp");
    for (int i = 0; i < 4; i++)
      chk($sformatf("ramp_l1_%0d", ramp_tab[i].pix),
          l1[ramp_tab[i].pix], ramp_tab[i].exp);
    full_compare("ramp_all");
    chk("ramp_done_cnt", done_cnt, 1);
    chk("ramp_busy_after", busy, 0);
    chk("ramp_cwr_cnt", cwr_cnt, 1024);
    chk("first_crd_cyc", first_crd, t_start + 1);
    chk("first_crd_addrs",
        {crd_a[0], crd_a[1], crd_a[2], crd_a[3]},
        {12'd0, 12'd1, 12'd64, 12'd65});
    chk("first_cwr_cyc", first_cwr, t_start + 6);
    chk("first_cwr_addr_sel", {fw_addr, fw_sel},
        {12'd0, 3'b011});
    chk("last_cwr_cyc", last_cwr, t_start + 6144);
    chk("done_cyc", done_cyc, t_start + 6145);
    chk("ramp_protocol", viol, 0);

    // Signed windows over random background
    for (int i = 0; i < 4096; i++) l0[i] = 20'($urandom);
    for (int i = 0; i < 3; i++)
      if (sgn_tab[i].load) load_window(sgn_tab[i]);
    do_run("signed");
    for (int i = 0; i < 3; i++)
      chk($sformatf("signed_l1_%0d", sgn_tab[i].pix),
          l1[sgn_tab[i].pix], sgn_tab[i].exp);
    full_compare("signed_all");
    chk("signed_protocol", viol, 0);

    // Reset in the middle of a layer
    for (int i = 0; i < 4096; i++) l0[i] = 20'(i);
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (cwr_cnt < 100 && n < 1000) begin
      tick();
      n++;
    end
    chk("midop_reach_100", cwr_cnt, 100);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midop_busy", busy, 0);
    chk("midop_csel", mif.csel, 0);
    c0 = cwr_cnt;
    repeat (20) tick();
    chk("midop_no_cwr", cwr_cnt, c0);
    chk("midop_cwr_total", cwr_cnt, 100);
    chk("midop_no_done", done_cnt, 0);
    do_run("after_reset");
    full_compare("after_reset_all");
    chk("after_reset_done", done_cnt, 1);

    // start re-pulsed while busy
    for (int i = 0; i < 4096; i++) l0[i] = 20'($urandom);
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 7000) begin
      n++;
      start = (n % 50 == 0) && busy;
      tick();
    end
    start = 1'b0;
    repeat (60) tick();
    chk("repulse_cwr_cnt", cwr_cnt, 1024);
    chk("repulse_done_cnt", done_cnt, 1);
    chk("repulse_busy", busy, 0);
    full_compare("repulse_all");

    // Random data, random start delay
    for (int i = 0; i < 4096; i++) l0[i] = 20'($urandom);
    repeat ($urandom_range(0, 7)) tick();
    do_run("random");
    full_compare("random_all");
    chk("random_protocol", viol, 0);
    chk("random_last_cwr", last_cwr, t_start + 6144);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
